// File: rtl/stream_mem_writer_pkg.sv
// -----------------------------------------------------------------------------
// stream_mem_writer_pkg
// Shared types and constants for the stream-to-memory write engine:
//   - state_t     : control FSM states
//   - BURST_INCR  : AXI INCR burst encoding
//   - RESP_OKAY   : AXI OKAY response encoding
//   - BOUNDARY_4K : AXI bursts may not cross this byte boundary
// -----------------------------------------------------------------------------
package stream_mem_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/stream_mem_writer_burst_calc.sv
// -----------------------------------------------------------------------------
// stream_mem_writer_burst_calc
// Combinational burst sizing: burst = min(remaining, MAX_BURST, beats to 4 KB).
// Ports:
//   addr      in  12     byte offset of the burst start within its 4 KB page
//                        (beat aligned)
//   remaining in  LEN_W  beats not yet assigned to a burst
//   burst     out 9      beats in the next burst (1..256 when remaining != 0)
//   awlen     out 8      burst - 1, as driven on the AW channel
// -----------------------------------------------------------------------------
module stream_mem_writer_burst_calc
    import stream_mem_writer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic [11:0]      addr,
    input  logic [LEN_W-1:0] remaining,
    output logic [8:0]       burst,
    output logic [7:0]       awlen
);

    localparam int SIZE_LOG2 = $clog2(DATA_W / 8);
    // Wide enough for both the length and the 4 KB beat count (up to 1024).
    localparam int CW = (LEN_W > 13) ? LEN_W : 13;

    logic [12:0]   bytes_to_4k;
    logic [CW-1:0] beats_to_4k;
    logic [CW-1:0] limit;

    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr};
        beats_to_4k = CW'(bytes_to_4k >> SIZE_LOG2);
        limit       = CW'(remaining);
        if (limit > CW'(MAX_BURST)) begin
            limit = CW'(MAX_BURST);
        end
        if (limit > beats_to_4k) begin
            limit = beats_to_4k;
        end
        burst = 9'(limit);
        awlen = 8'(burst - 9'd1);
    end

endmodule

// File: rtl/stream_mem_writer.sv
// -----------------------------------------------------------------------------
// stream_mem_writer
// Takes an AXI-Stream of result beats and writes them to memory as AXI4 INCR
// bursts from a programmed base address, one burst outstanding at a time.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, base_addr,        transfer request (accepted only when idle)
//   len_beats
//   busy, done, error,       status; error/truncated/beats_written are valid
//   truncated, beats_written with done and hold until the next start
//   s_t*                     AXIS slave input
//   m_aw*, m_w*, m_b*        AXI4 write master (AW, W, B channels)
// -----------------------------------------------------------------------------
module stream_mem_writer
    import stream_mem_writer_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    len_beats,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                truncated,
    output logic [LEN_W-1:0]    beats_written,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_tvalid,
    input  logic                s_tlast,
    output logic                s_tready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    localparam int                BYTES      = DATA_W / 8;
    localparam int                SIZE_LOG2  = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;      // beats not yet in a burst
    logic [LEN_W-1:0]  beats_written_q, beats_written_d;
    logic [8:0]        burst_q, burst_d;              // size of current burst
    logic [8:0]        beat_cnt_q, beat_cnt_d;        // beats owed in current burst
    logic              pad_q, pad_d;
    logic              tlast_seen_q, tlast_seen_d;
    logic              error_q, error_d;
    logic              truncated_q, truncated_d;

    logic [8:0]        calc_burst;
    logic [7:0]        calc_awlen;

    stream_mem_writer_burst_calc #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .addr      (addr_q[11:0]),
        .remaining (remaining_q),
        .burst     (calc_burst),
        .awlen     (calc_awlen)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (len_beats == '0) ? ST_DONE : ST_AW;
            ST_AW:   if (m_awready) state_d = ST_W;
            ST_W:    if (m_wvalid && m_wready && m_wlast) state_d = ST_B;
            ST_B: begin
                if (m_bvalid) begin
                    if (m_bresp != RESP_OKAY || remaining_q == '0 || tlast_seen_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_AW;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: the W path is a straight combinational pass-through of the stream.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        m_awvalid = 1'b0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_awburst = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        s_tready  = 1'b0;
        m_bready  = 1'b0;
        case (state_q)
            ST_AW: begin
                // addr_q/remaining_q are frozen in AW, so the fields stay stable.
                m_awvalid = 1'b1;
                m_awaddr  = addr_q;
                m_awlen   = calc_awlen;
                m_awsize  = 3'(SIZE_LOG2);
                m_awburst = BURST_INCR;
            end
            ST_W: begin
                m_wlast = (beat_cnt_q == 9'd1);
                if (pad_q) begin
                    // Stream ended early: fill the burst with null-strobe beats.
                    m_wvalid = 1'b1;
                end else begin
                    m_wvalid = s_tvalid;
                    s_tready = m_wready;
                    m_wdata  = s_tdata;
                    m_wstrb  = '1;
                end
            end
            ST_B:    m_bready = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        addr_d          = addr_q;
        len_d           = len_q;
        remaining_d     = remaining_q;
        beats_written_d = beats_written_q;
        burst_d         = burst_q;
        beat_cnt_d      = beat_cnt_q;
        pad_d           = pad_q;
        tlast_seen_d    = tlast_seen_q;
        error_d         = error_q;
        truncated_d     = truncated_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d          = base_addr & ALIGN_MASK;
                    len_d           = len_beats;
                    remaining_d     = len_beats;
                    beats_written_d = '0;
                    pad_d           = 1'b0;
                    tlast_seen_d    = 1'b0;
                    error_d         = 1'b0;
                    truncated_d     = 1'b0;
                end
            end
            ST_AW: begin
                if (m_awready) begin
                    burst_d     = calc_burst;
                    beat_cnt_d  = calc_burst;
                    remaining_d = remaining_q - LEN_W'(calc_burst);
                end
            end
            ST_W: begin
                if (m_wvalid && m_wready) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (!pad_q) begin
                        beats_written_d = beats_written_q + LEN_W'(1);
                        if (s_tlast) begin
                            tlast_seen_d = 1'b1;
                            if (beats_written_q + LEN_W'(1) < len_q) begin
                                truncated_d = 1'b1;
                            end
                            if (beat_cnt_q != 9'd1) begin
                                pad_d = 1'b1;
                            end
                        end
                    end
                    if (m_wlast) begin
                        pad_d = 1'b0;
                    end
                end
            end
            ST_B: begin
                if (m_bvalid) begin
                    if (m_bresp != RESP_OKAY) begin
                        error_d = 1'b1;
                    end else if (remaining_q != '0 && !tlast_seen_q) begin
                        addr_d = addr_q + (ADDR_W'(burst_q) << SIZE_LOG2);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            len_q           <= '0;
            remaining_q     <= '0;
            beats_written_q <= '0;
            burst_q         <= '0;
            beat_cnt_q      <= '0;
            pad_q           <= 1'b0;
            tlast_seen_q    <= 1'b0;
            error_q         <= 1'b0;
            truncated_q     <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            len_q           <= len_d;
            remaining_q     <= remaining_d;
            beats_written_q <= beats_written_d;
            burst_q         <= burst_d;
            beat_cnt_q      <= beat_cnt_d;
            pad_q           <= pad_d;
            tlast_seen_q    <= tlast_seen_d;
            error_q         <= error_d;
            truncated_q     <= truncated_d;
        end
    end

    assign error         = error_q;
    assign truncated     = truncated_q;
    assign beats_written = beats_written_q;

endmodule

// File: tb/tb_stream_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_stream_mem_writer
// Self-checking bench for stream_mem_writer (DATA_W=32, MAX_BURST=16).
// A transfer-level reference model predicts the AW sequence, every W beat and
// the final status; a small AXI slave / AXIS source model drives the DUT with
// optional random backpressure.
// -----------------------------------------------------------------------------
module tb_stream_mem_writer;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 16;
    localparam int MAX_BURST = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len_beats;
    logic              busy, done, error, truncated;
    logic [LEN_W-1:0]  beats_written;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid, s_tlast, s_tready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_awvalid, m_awready;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_wlast, m_wvalid, m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid, m_bready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] sdata [0:127];
    logic [31:0] exp_aw_addr [$];
    logic [7:0]  exp_aw_len  [$];
    logic [31:0] exp_w_data  [$];
    logic [3:0]  exp_w_strb  [$];
    logic        exp_w_last  [$];
    logic        exp_err, exp_trunc;
    int          exp_bw;

    stream_mem_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .len_beats(len_beats), .busy(busy), .done(done), .error(error),
        .truncated(truncated), .beats_written(beats_written),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Transfer-level model: split into legal bursts, fill each burst from the
    // stream until tlast, pad the rest, stop after an error or after tlast.
    task automatic build_model(input logic [31:0] base, input int len,
                               input int tlast_at, input int err_burst);
        int unsigned a, rem, b, b4k;
        int k, nb;
        bit ended;
        exp_aw_addr.delete(); exp_aw_len.delete();
        exp_w_data.delete(); exp_w_strb.delete(); exp_w_last.delete();
        a = base & 32'hFFFF_FFFC;
        rem = len; k = 0; nb = 0; ended = 0; exp_err = 0;
        while (rem > 0) begin
            b = rem;
            if (b > MAX_BURST) b = MAX_BURST;
            b4k = (4096 - (a % 4096)) / 4;
            if (b4k < b) b = b4k;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(8'(b - 1));
            for (int j = 0; j < int'(b); j++) begin
                if (!ended) begin
                    exp_w_data.push_back(sdata[k]);
                    exp_w_strb.push_back(4'hF);
                    if (tlast_at == k + 1) ended = 1;
                    k++;
                end else begin
                    exp_w_data.push_back(32'h0);
                    exp_w_strb.push_back(4'h0);
                end
                exp_w_last.push_back(j == int'(b) - 1);
            end
            rem -= b;
            a += b * 4;
            if (nb == err_burst) begin
                exp_err = 1;
                break;
            end
            nb++;
            if (ended) break;
        end
        exp_bw = k;
        exp_trunc = ended && (k < len);
    endtask

    task automatic run_xfer(input logic [31:0] base, input int len, input int tlast_at,
                            input int err_burst, input bit bp);
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_pend = 0, sent = 0, cyc = 0;
        bit got_done = 0, t_hold = 0, b_hold = 0, aw_wait = 0, w_wait = 0;
        logic [31:0] p_awaddr, p_wdata;
        logic [7:0]  p_awlen;
        logic [3:0]  p_wstrb;
        logic        p_wlast;
        for (int i = 0; i < 128; i++) sdata[i] = $urandom;
        build_model(base, len, tlast_at, err_burst);
        @(negedge clk);
        base_addr = base;
        len_beats = 16'(len);
        start = 1'b1;
        while (!got_done && cyc < 3000) begin
            if (cyc > 0) begin
                @(negedge clk);
                start = 1'b0;
            end
            m_awready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_wready  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!t_hold) s_tvalid = (sent < len + 4) && (!bp || $urandom_range(0, 1) == 1);
            s_tdata = sdata[sent];
            s_tlast = (tlast_at == sent + 1);
            if (!b_hold) m_bvalid = (b_pend > 0) && (!bp || $urandom_range(0, 1) == 1);
            m_bresp = (b_cnt == err_burst) ? 2'b10 : 2'b00;
            #1;
            if (aw_wait) begin
                check("aw_valid_held", m_awvalid, 1);
                check("aw_addr_stable", m_awaddr, p_awaddr);
                check("aw_len_stable", m_awlen, p_awlen);
            end
            if (w_wait) begin
                check("w_valid_held", m_wvalid, 1);
                check("w_data_stable", m_wdata, p_wdata);
                check("w_strb_stable", m_wstrb, p_wstrb);
                check("w_last_stable", m_wlast, p_wlast);
            end
            aw_wait = m_awvalid && !m_awready;
            w_wait  = m_wvalid && !m_wready;
            p_awaddr = m_awaddr; p_awlen = m_awlen;
            p_wdata = m_wdata; p_wstrb = m_wstrb; p_wlast = m_wlast;
            if (m_awvalid && m_awready) begin
                check("aw_one_outstanding", 64'(aw_cnt - b_cnt), 0);
                if (aw_cnt < exp_aw_addr.size()) begin
                    check("aw_addr", m_awaddr, exp_aw_addr[aw_cnt]);
                    check("aw_len", m_awlen, exp_aw_len[aw_cnt]);
                end else begin
                    check("aw_unexpected", 64'(aw_cnt), 64'(exp_aw_addr.size()));
                end
                check("aw_size", m_awsize, 3'd2);
                check("aw_burst", m_awburst, 2'b01);
                aw_cnt++;
            end
            if (m_wvalid && m_wready) begin
                if (w_cnt < exp_w_data.size()) begin
                    check("w_data", m_wdata, exp_w_data[w_cnt]);
                    check("w_strb", m_wstrb, exp_w_strb[w_cnt]);
                    check("w_last", m_wlast, exp_w_last[w_cnt]);
                end else begin
                    check("w_unexpected", 64'(w_cnt), 64'(exp_w_data.size()));
                end
                if (m_wlast) b_pend++;
                w_cnt++;
            end
            if (s_tvalid && s_tready) sent++;
            t_hold = s_tvalid && !s_tready;
            if (m_bvalid && m_bready) begin
                b_pend--;
                b_cnt++;
            end
            b_hold = m_bvalid && !m_bready;
            if (done) begin
                got_done = 1;
                check("done_error", error, exp_err);
                check("done_truncated", truncated, exp_trunc);
                check("done_beats_written", beats_written, 64'(exp_bw));
                check("aw_count", 64'(aw_cnt), 64'(exp_aw_addr.size()));
                check("w_count", 64'(w_cnt), 64'(exp_w_data.size()));
                check("stream_consumed", 64'(sent), 64'(exp_bw));
            end
            cyc++;
        end
        if (!got_done) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            m_bvalid = 1'b0;
            #1;
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
            check("tready_idle", s_tready, 0);
            check("error_hold", error, exp_err);
            check("bw_hold", beats_written, 64'(exp_bw));
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    initial begin
        int len, tl, eb;
        logic [31:0] base;
        rst = 1'b1; start = 1'b0; base_addr = '0; len_beats = '0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_truncated", truncated, 0);
        check("rst_beats_written", beats_written, 0);
        check("rst_tready", s_tready, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_wlast", m_wlast, 0);
        check("rst_bready", m_bready, 0);
        check("rst_awaddr", m_awaddr, 0);
        check("rst_wdata", m_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        run_xfer(32'h1000, 4, 0, -1, 0);
        run_xfer(32'h0000, 40, 0, -1, 0);
        run_xfer(32'h0FF8, 8, 0, -1, 0);
        run_xfer(32'h0000, 8, 3, -1, 0);
        run_xfer(32'h0000, 40, 0, 1, 1);

        // Reset in the middle of a W burst.
        @(negedge clk);
        base_addr = 32'h200; len_beats = 16'd20; start = 1'b1;
        s_tvalid = 1'b0; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("midw_busy", busy, 1);
        check("midw_tready", s_tready, 1);
        s_tvalid = 1'b1; s_tdata = 32'hCAFE_0001;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_midw_busy", busy, 0);
        check("rst_midw_tready", s_tready, 0);
        check("rst_midw_awvalid", m_awvalid, 0);
        check("rst_midw_wvalid", m_wvalid, 0);
        check("rst_midw_bready", m_bready, 0);
        check("rst_midw_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 1'b0;
        run_xfer(32'h40, 0, 0, -1, 0);

        for (int n = 0; n < 20; n++) begin
            base = ($urandom_range(0, 3) == 0) ? (32'h0FC0 + $urandom_range(0, 63))
                                               : $urandom_range(0, 32'h1FFF);
            len = $urandom_range(0, 60);
            tl  = ($urandom_range(0, 2) == 0 && len > 0) ? $urandom_range(1, len + 2) : 0;
            eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            run_xfer(base, len, tl, eb, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_mem_writer.md
Name: stream_mem_writer

Overview:
Stream-to-memory write engine: the return path that takes accelerator output back into memory. Accepts an AXI-Stream of result beats and writes them to memory as AXI4 INCR write bursts starting at a programmed base address. Sits between the accelerator stream output and the memory-side AXI slave port, and is controlled by start/length/base registers from the memory map. Single clock domain, one burst outstanding at a time.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI/AXIS data width in bits; power of two, 32..512
LEN_W, 16, width of the transfer length in beats
MAX_BURST, 16, maximum beats per AXI burst; power of two, 1..256

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; accepted only in IDLE
base_addr  in  ADDR_W  byte address of first beat; low log2(DATA_W/8) bits are forced to 0
len_beats  in  LEN_W  number of beats to write
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transfer
error  out  1  valid with done: a BRESP was not OKAY
truncated  out  1  valid with done: tlast arrived before len_beats was reached
beats_written  out  LEN_W  stream beats consumed; valid with done
s_tdata / s_tvalid / s_tlast  in  DATA_W/1/1  AXIS slave input
s_tready  out  1  AXIS ready
m_awaddr / m_awlen / m_awsize / m_awburst  out  ADDR_W/8/3/2  AW channel
m_awvalid  out  1  AW valid
m_awready  in  1  AW ready
m_wdata / m_wstrb / m_wlast / m_wvalid  out  DATA_W/DATA_W/8/1/1  W channel
m_wready  in  1  W ready
m_bresp  in  2  B response
m_bvalid  in  1  B valid
m_bready  out  1  B ready

Behaviour:
- Reset values: busy=0, done=0, error=0, truncated=0, beats_written=0, s_tready=0, m_awvalid=0, m_wvalid=0, m_wlast=0, m_bready=0, and all address/data outputs 0. The state machine returns to IDLE. Reset mid-burst abandons the burst; no completion is generated.
- States: IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
- IDLE
  - On start, latch base_addr (aligned), len_beats, and clear counters and flags.
  - If len_beats==0, go to DONE with no bus activity. Otherwise go to AW.
  - start outside IDLE is ignored.
- Burst length: burst = min(remaining, MAX_BURST, beats_to_4k), where beats_to_4k = (4096 - addr[11:0]) >> log2(DATA_W/8).
- AW state
  - m_awvalid=1 with m_awlen=burst-1, m_awsize=log2(DATA_W/8), m_awburst=INCR (2'b01).
  - All AW fields are stable while valid and not ready.
  - On handshake, go to W with beat counter = burst.
- W state
  - Normal mode: m_wvalid=s_tvalid, s_tready=m_wready, m_wdata=s_tdata, m_wstrb all ones. The path is combinational, so there is zero added latency.
  - m_wlast=1 on the last beat of the burst. The stream's tlast is not copied to wlast.
  - Pad mode: entered after an accepted s_tlast with beats still owed in the burst. In pad mode s_tready=0, m_wvalid=1, m_wstrb=0, and m_wdata=0 until the burst's wlast handshake completes. Padded beats are not counted in beats_written.
  - On the wlast handshake, go to B.
- B state
  - m_bready=1.
  - On bvalid: if bresp!=OKAY, set error and go to DONE.
  - Else, if remaining==0 or tlast was seen, go to DONE.
  - Else advance addr by burst*(DATA_W/8) and go to AW.
- DONE: done=1 for exactly one cycle, busy=0 on the following cycle, then IDLE. error, truncated and beats_written hold until the next accepted start.
- Stream beats beyond len_beats are not consumed; s_tready=0 outside W state.
- tlast exactly on beat len_beats: normal completion, truncated=0.

Decomposition:
- Package stream_mem_writer_pkg holds:
  - the state enum (IDLE, AW, W, B, DONE)
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00
  - the 4 KB boundary constant 4096
- Sub-module stream_mem_writer_burst_calc is purely combinational. Inputs: addr, remaining. Outputs: burst beats and awlen.

Test Plan:
- DATA_W=32. base 0x1000, len 4, always-ready slave -> one AW (addr 0x1000, awlen=3, awsize=2), 4 W beats with wlast on the 4th, done pulse, beats_written=4, error=0.
- base 0x0, len 40, MAX_BURST=16 -> AWs at 0x0/0x40/0x80 with awlen 15/15/7. No second AW is issued before the prior B.
- base 0xFF8, len 8 -> burst 1 at 0xFF8 with awlen=1, burst 2 at 0x1000 with awlen=5. No burst crosses 4 KB.
- len 8, s_tlast on beat 3 -> 3 data beats with wstrb=0xF, then 5 pad beats with wstrb=0 and wlast on beat 8. Result: truncated=1, beats_written=3.
- Second B returns SLVERR during a 40-beat transfer -> no third AW, done with error=1. Random wready/tvalid/awready backpressure holds AW/W fields stable while valid.
- rst asserted mid-W -> next cycle all valids/readys are 0 and busy=0. A subsequent start with len 0 gives a done pulse with no AW issued.
